// File: rtl/audio_i2s_sink_if.sv
`default_nettype none
// ============================================================================
// Module      : audio_i2s_sink_if
// Description : Left/right 16-bit Avalon-ST sample streams feeding the I2S
//               sink. The source drives DATA/VALID, the sink drives READY.
// Revision    : 1.0 - initial release
// ============================================================================
interface audio_i2s_sink_if;
    logic [15:0] L_DATA;
    logic        L_VALID;
    logic        L_READY;
    logic [15:0] R_DATA;
    logic        R_VALID;
    logic        R_READY;

    modport master (
        output L_DATA, L_VALID, R_DATA, R_VALID,
        input  L_READY, R_READY
    );

    modport slave (
        input  L_DATA, L_VALID, R_DATA, R_VALID,
        output L_READY, R_READY
    );
endinterface
`default_nettype wire

// File: rtl/audio_i2s_sink.sv
`default_nettype none
// ============================================================================
// Module      : audio_i2s_sink
// Description : Buffers one 16-bit sample per channel and serializes both as
//               standard I2S (MSB one BCLK after the LRCK edge) towards the
//               WM8731 DAC. BCLK/LRCK are divided down from clk. A channel
//               that has no fresh sample at a frame start is counted as an
//               underflow (saturating).
// Options     : define AUDIO_UNDERFLOW_HOLD_EN to replay the last sample of a
//               starved channel instead of sending silence.
// Revision    : 1.0 - initial release
// ============================================================================
module audio_i2s_sink #(
    parameter int CLK_DIV   = 8,
    parameter int SLOT_BITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    audio_i2s_sink_if.slave    st,
    output logic               AUD_BCLK,
    output logic               AUD_DACLRCK,
    output logic               AUD_DACDAT,
    output logic [15:0]        underflow_count
);

    localparam int c_DIV_W      = $clog2(CLK_DIV);
    localparam int c_FRAME_BITS = 2 * SLOT_BITS;
    localparam int c_BIT_W      = $clog2(c_FRAME_BITS);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(c_FRAME_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_SLOT     = c_BIT_W'(SLOT_BITS);
    localparam logic [c_BIT_W-1:0] c_ONE      = c_BIT_W'(1);
    localparam logic [c_BIT_W-1:0] c_SIXTEEN  = c_BIT_W'(16);

    // Clock generation
    logic [c_DIV_W-1:0] r_div_cnt;
    logic               r_bclk;
    logic               w_div_wrap;
    logic               w_fall;

    // Frame position and pins
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [c_BIT_W-1:0] w_bit_next;
    logic               r_lrck;
    logic               r_dat;
    logic               w_load;
    logic               w_lrck_next;
    logic [c_BIT_W-1:0] w_pos;
    logic               w_in_word;
    logic [3:0]         w_idx;
    logic [15:0]        w_shift_sel;
    logic               w_dat_next;

    // Holding / shift registers
    logic [15:0]        r_hold_l;
    logic [15:0]        r_hold_r;
    logic               r_full_l;
    logic               r_full_r;
    logic [15:0]        r_shift_l;
    logic [15:0]        r_shift_r;
    logic               w_ready_l;
    logic               w_ready_r;
    logic               w_acc_l;
    logic               w_acc_r;
    logic [15:0]        w_fill_l;
    logic [15:0]        w_fill_r;

    // Underflow accounting
    logic [15:0]        r_underflow;
    logic [1:0]         w_starved;
    logic [16:0]        w_uf_sum;
    logic [15:0]        w_uf_next;

    assign w_div_wrap = (r_div_cnt == c_DIV_LAST);
    assign w_fall     = w_div_wrap & r_bclk;
    assign w_bit_next = (r_bit_cnt == c_BIT_LAST) ? '0 : r_bit_cnt + c_ONE;
    // The fall that wraps the frame position back to 0 is the frame load.
    assign w_load     = w_fall & (r_bit_cnt == c_BIT_LAST);

    // Pin values for the position the bit counter is about to enter.
    assign w_lrck_next = (w_bit_next >= c_SLOT);
    assign w_pos       = w_lrck_next ? (w_bit_next - c_SLOT) : w_bit_next;
    assign w_in_word   = (w_pos >= c_ONE) && (w_pos <= c_SIXTEEN);
    assign w_idx       = 4'(c_SIXTEEN - w_pos);
    assign w_shift_sel = w_lrck_next ? r_shift_r : r_shift_l;
    assign w_dat_next  = w_in_word & w_shift_sel[w_idx];

    assign w_ready_l  = ~r_full_l & ~reset;
    assign w_ready_r  = ~r_full_r & ~reset;
    assign w_acc_l    = st.L_VALID & w_ready_l;
    assign w_acc_r    = st.R_VALID & w_ready_r;
    assign st.L_READY = w_ready_l;
    assign st.R_READY = w_ready_r;

`ifdef AUDIO_UNDERFLOW_HOLD_EN
    // Replaying the previous word keeps the DAC output level, avoiding clicks.
    assign w_fill_l = r_shift_l;
    assign w_fill_r = r_shift_r;
`else
    assign w_fill_l = 16'h0000;
    assign w_fill_r = 16'h0000;
`endif

    assign w_starved = {1'b0, ~r_full_l} + {1'b0, ~r_full_r};
    assign w_uf_sum  = {1'b0, r_underflow} + {15'd0, w_starved};
    assign w_uf_next = w_uf_sum[16] ? 16'hFFFF : w_uf_sum[15:0];

    assign AUD_BCLK        = r_bclk;
    assign AUD_DACLRCK     = r_lrck;
    assign AUD_DACDAT      = r_dat;
    assign underflow_count = r_underflow;

    // Divide clk down to BCLK: toggle every CLK_DIV cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_bclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + c_DIV_W'(1);
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end
        end
    end

    // Advance the frame position and update the I2S pins on BCLK falls only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= c_BIT_LAST;
            r_lrck    <= 1'b1;
            r_dat     <= 1'b0;
        end else if (w_fall) begin
            r_bit_cnt <= w_bit_next;
            r_lrck    <= w_lrck_next;
            r_dat     <= w_dat_next;
        end
    end

    // Left channel: accept into hold, move hold (or fill) to shift at frame load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_l  <= '0;
            r_full_l  <= 1'b0;
            r_shift_l <= '0;
        end else begin
            if (w_load) begin
                r_shift_l <= r_full_l ? r_hold_l : w_fill_l;
            end
            if (w_acc_l) begin
                r_hold_l <= st.L_DATA;
                r_full_l <= 1'b1;
            end else if (w_load) begin
                r_full_l <= 1'b0;
            end
        end
    end

    // Right channel: same holding/shift behaviour as the left channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hold_r  <= '0;
            r_full_r  <= 1'b0;
            r_shift_r <= '0;
        end else begin
            if (w_load) begin
                r_shift_r <= r_full_r ? r_hold_r : w_fill_r;
            end
            if (w_acc_r) begin
                r_hold_r <= st.R_DATA;
                r_full_r <= 1'b1;
            end else if (w_load) begin
                r_full_r <= 1'b0;
            end
        end
    end

    // Count starved channels at each frame load, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underflow <= '0;
        end else if (w_load && (w_starved != 2'd0)) begin
            r_underflow <= w_uf_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_i2s_sink.sv
`default_nettype none
// ============================================================================
// Module      : tb_audio_i2s_sink
// Description : Self-checking bench for audio_i2s_sink. A cycle-count based
//               reference model predicts pins, READY and underflow_count;
//               scenario tasks add explicit checks of the documented cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_i2s_sink;

    localparam int c_DIV   = 8;
    localparam int c_SLOT  = 32;
    localparam int c_HALF  = 2 * c_DIV;            // clk cycles per BCLK period
    localparam int c_FRAME = 2 * c_SLOT * c_HALF;  // clk cycles per frame

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        AUD_BCLK;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic [15:0] underflow_count;

    audio_i2s_sink_if st ();

    audio_i2s_sink #(.CLK_DIV(c_DIV), .SLOT_BITS(c_SLOT)) dut (
        .clk             (clk),
        .reset           (reset),
        .st              (st),
        .AUD_BCLK        (AUD_BCLK),
        .AUD_DACLRCK     (AUD_DACLRCK),
        .AUD_DACDAT      (AUD_DACDAT),
        .underflow_count (underflow_count)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

`ifdef AUDIO_UNDERFLOW_HOLD_EN
    localparam logic c_HOLD = 1'b1;
`else
    localparam logic c_HOLD = 1'b0;
`endif

    // ---------------- reference model ----------------
    int          n = 0;         // posedges since reset release
    logic        m_full_l = 0, m_full_r = 0;
    logic        m_acc_l = 0, m_acc_r = 0, m_load = 0;
    logic [15:0] m_hold_l = 0, m_hold_r = 0, m_cur_l = 0, m_cur_r = 0, m_cnt = 0;
    logic        m_bclk = 0, m_lrck = 1, m_dat = 0;
    int          mk, mbp, mp;
    logic [15:0] mcur;

    initial begin
        forever begin
            @(posedge clk);
            m_load  = 1'b0;
            m_acc_l = 1'b0;
            m_acc_r = 1'b0;
            if (reset) begin
                n = 0;
                m_full_l = 0; m_full_r = 0;
                m_hold_l = 0; m_hold_r = 0;
                m_cur_l  = 0; m_cur_r  = 0;
                m_cnt    = 0;
            end else begin
                n = n + 1;
                m_acc_l = st.L_VALID && !m_full_l;
                m_acc_r = st.R_VALID && !m_full_r;
                if (n >= c_HALF && ((n - c_HALF) % c_FRAME) == 0) begin
                    m_load = 1'b1;
                    if (m_full_l) begin
                        m_cur_l = m_hold_l; m_full_l = 0;
                    end else begin
                        if (!c_HOLD) m_cur_l = 16'h0000;
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    end
                    if (m_full_r) begin
                        m_cur_r = m_hold_r; m_full_r = 0;
                    end else begin
                        if (!c_HOLD) m_cur_r = 16'h0000;
                        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                    end
                end
                if (m_acc_l) begin m_hold_l = st.L_DATA; m_full_l = 1; end
                if (m_acc_r) begin m_hold_r = st.R_DATA; m_full_r = 1; end
            end
            m_bclk = ((n / c_DIV) % 2) == 1;
            if (n < c_HALF) begin
                m_lrck = 1'b1;
                m_dat  = 1'b0;
            end else begin
                mk     = n / c_HALF;
                mbp    = (mk - 1) % (2 * c_SLOT);
                m_lrck = (mbp >= c_SLOT);
                mp     = mbp % c_SLOT;
                mcur   = m_lrck ? m_cur_r : m_cur_l;
                m_dat  = (mp >= 1 && mp <= 16) ? mcur[16 - mp] : 1'b0;
            end
        end
    end

    logic [20:0] exp_vec;
    logic [20:0] dut_vec;
    assign exp_vec = {m_bclk, m_lrck, m_dat, ~m_full_l & ~reset, ~m_full_r & ~reset, m_cnt};
    assign dut_vec = {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, st.L_READY, st.R_READY, underflow_count};

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut_vec !== 21'b0_1_0_0_0_0000000000000000) begin
            n_err++; $display("FAIL reset_values: got %h expected %h", dut_vec, 21'h080000);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({st.L_READY, st.R_READY} !== 2'b11) begin
            n_err++; $display("FAIL ready_after_reset: got %b expected 11", {st.L_READY, st.R_READY});
        end
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL pins_reset n=%0d: got %h expected %h", n, dut_vec, exp_vec);
            end
            if (c == 7 || c == 8 || c == 15 || c == 16) begin
                n_cmp++;
                if (c == 7 && AUD_BCLK !== 1'b0) begin
                    n_err++; $display("FAIL bclk_c7: got %b expected 0", AUD_BCLK);
                end
                if (c == 8 && AUD_BCLK !== 1'b1) begin
                    n_err++; $display("FAIL bclk_rise_c8: got %b expected 1", AUD_BCLK);
                end
                if (c == 15 && {AUD_BCLK, AUD_DACLRCK} !== 2'b11) begin
                    n_err++; $display("FAIL before_fall_c15: got %b expected 11", {AUD_BCLK, AUD_DACLRCK});
                end
                if (c == 16 && {AUD_BCLK, AUD_DACLRCK, underflow_count} !== {2'b00, 16'd2}) begin
                    n_err++; $display("FAIL first_load_c16: got %h expected %h",
                                      {AUD_BCLK, AUD_DACLRCK, underflow_count}, {2'b00, 16'd2});
                end
            end
        end
    endtask

    task automatic test_known_pattern();
        logic [63:0] cap, lrv, exp_cap, exp_lrv;
        int          idx;
        logic        prev;
        exp_cap = {1'b0, 16'hA5C3, 15'h0, 1'b0, 16'h8001, 15'h0};
        exp_lrv = {32'h0, 32'hFFFF_FFFF};
        cap = '0; lrv = '0; idx = 0;
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        st.L_DATA = 16'hA5C3; st.L_VALID = 1'b1;
        st.R_DATA = 16'h8001; st.R_VALID = 1'b1;
        prev = AUD_BCLK;
        for (int c = 1; c <= c_FRAME + c_HALF; c++) begin
            @(negedge clk);
            if (c == 1) begin st.L_VALID = 1'b0; st.R_VALID = 1'b0; end
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL pins_known n=%0d: got %h expected %h", n, dut_vec, exp_vec);
            end
            if (c == c_HALF + 1) begin
                n_cmp++;
                if (underflow_count !== 16'd0) begin
                    n_err++; $display("FAIL known_no_underflow: got %0d expected 0", underflow_count);
                end
            end
            if (!prev && AUD_BCLK && c > c_HALF && idx < 64) begin
                cap[63 - idx] = AUD_DACDAT;
                lrv[63 - idx] = AUD_DACLRCK;
                idx++;
            end
            prev = AUD_BCLK;
        end
        n_cmp++;
        if (idx !== 64 || cap !== exp_cap || lrv !== exp_lrv) begin
            n_err++; $display("FAIL known_frame: got bits %h lrck %h (%0d rises) expected %h %h (64)",
                              cap, lrv, idx, exp_cap, exp_lrv);
        end
    endtask

    task automatic test_back_to_back();
        int   acc_l, acc_r, hi_l;
        logic started;
        started = 0; acc_l = 0; acc_r = 0; hi_l = 0;
        st.L_VALID = 1'b1; st.L_DATA = 16'($urandom);
        st.R_VALID = 1'b1; st.R_DATA = 16'($urandom);
        for (int c = 0; c < 4 * c_FRAME; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL pins_b2b n=%0d: got %h expected %h", n, dut_vec, exp_vec);
            end
            if (m_acc_l) st.L_DATA = 16'($urandom);
            if (m_acc_r) st.R_DATA = 16'($urandom);
            if (m_load) begin
                if (started) begin
                    n_cmp++;
                    if (acc_l !== 1 || acc_r !== 1 || hi_l !== 1) begin
                        n_err++; $display("FAIL b2b_per_frame: got accL=%0d accR=%0d readyL_cycles=%0d expected 1 1 1",
                                          acc_l, acc_r, hi_l);
                    end
                end
                started = 1; acc_l = 0; acc_r = 0; hi_l = 0;
            end
            if (st.L_READY) hi_l++;
            if (st.L_VALID && st.L_READY) acc_l++;
            if (st.R_VALID && st.R_READY) acc_r++;
        end
    endtask

    task automatic test_starve();
        int          ld, idx;
        logic        prev;
        logic [15:0] cnt0, fill;
        logic [63:0] cap;
        fill = c_HOLD ? 16'h1234 : 16'h0000;
        ld = 0; idx = 0; cnt0 = 0; cap = '0;
        st.R_VALID = 1'b0;
        prev = AUD_BCLK;
        for (int c = 0; c < 5 * c_FRAME; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL pins_starve n=%0d: got %h expected %h", n, dut_vec, exp_vec);
            end
            if (m_acc_l) st.L_DATA = 16'($urandom);
            if (m_acc_r) st.R_VALID = 1'b0;
            if (m_load) begin
                ld++;
                if (ld == 1) begin st.R_DATA = 16'h1234; st.R_VALID = 1'b1; end
                if (ld == 2) cnt0 = underflow_count;
                if (ld == 3 || ld == 4) begin
                    n_cmp++;
                    if (underflow_count !== cnt0 + 16'(ld - 2)) begin
                        n_err++; $display("FAIL starve_count_ld%0d: got %0d expected %0d",
                                          ld, underflow_count, cnt0 + 16'(ld - 2));
                    end
                end
            end
            if (ld == 3 && !prev && AUD_BCLK && idx < 64) begin
                cap[63 - idx] = AUD_DACDAT;
                idx++;
            end
            prev = AUD_BCLK;
            if (ld == 4) break;
        end
        n_cmp++;
        if (ld !== 4 || idx !== 64 || cap[30:15] !== fill) begin
            n_err++; $display("FAIL starve_right_slot: got loads=%0d rises=%0d word=%h expected 4 64 %h",
                              ld, idx, cap[30:15], fill);
        end
    endtask

    task automatic test_load_collision();
        int          ph, idx;
        logic        prev;
        logic [15:0] cnt_b, sample;
        logic [63:0] cap;
        ph = 0; idx = 0; cnt_b = 0; cap = '0;
        sample = 16'($urandom) | 16'h8001;
        prev = AUD_BCLK;
        for (int c = 0; c < 3 * c_FRAME; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL pins_collide n=%0d: got %h expected %h", n, dut_vec, exp_vec);
            end
            if (m_acc_l) st.L_DATA = 16'($urandom);
            if (ph == 1) begin
                n_cmp++;
                if ({underflow_count, st.R_READY} !== {cnt_b + 16'd1, 1'b0}) begin
                    n_err++; $display("FAIL collide_load: got cnt=%0d ready=%b expected cnt=%0d ready=0",
                                      underflow_count, st.R_READY, cnt_b + 16'd1);
                end
                st.R_VALID = 1'b0;
                ph = 2;
            end else if (ph == 2 && m_load) begin
                ph = 3;
                n_cmp++;
                if (underflow_count !== cnt_b + 16'd1) begin
                    n_err++; $display("FAIL collide_next_load: got %0d expected %0d",
                                      underflow_count, cnt_b + 16'd1);
                end
            end else if (ph == 3 && m_load) begin
                ph = 4;
            end
            if (ph == 3 && !prev && AUD_BCLK && idx < 64) begin
                cap[63 - idx] = AUD_DACDAT;
                idx++;
            end
            if (ph == 0 && n >= c_HALF && ((n + 1 - c_HALF) % c_FRAME) == 0) begin
                cnt_b = underflow_count;
                st.R_DATA = sample; st.R_VALID = 1'b1;
                ph = 1;
            end
            prev = AUD_BCLK;
            if (ph == 4) break;
        end
        n_cmp++;
        if (ph !== 4 || idx !== 64 || cap[30:15] !== sample) begin
            n_err++; $display("FAIL collide_sample_plays: got phase=%0d rises=%0d word=%h expected 4 64 %h",
                              ph, idx, cap[30:15], sample);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic saw_one;
        saw_one = 1'b0;
        st.L_VALID = 1'b0;
        st.R_DATA  = 16'hFFFF; st.R_VALID = 1'b1;
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL pins_pre_reset n=%0d: got %h expected %h", n, dut_vec, exp_vec);
            end
            if (m_acc_r) st.R_VALID = 1'b0;
        end
        n_cmp++;
        if ({AUD_DACLRCK, st.R_READY} !== 2'b10) begin
            n_err++; $display("FAIL pre_reset_state: got lrck/readyR %b expected 10", {AUD_DACLRCK, st.R_READY});
        end
        reset = 1'b1;
        st.R_DATA = 16'hFFFF; st.R_VALID = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (dut_vec !== 21'b0_1_0_0_0_0000000000000000) begin
            n_err++; $display("FAIL mid_reset_values: got %h expected %h", dut_vec, 21'h080000);
        end
        reset = 1'b0;
        st.R_VALID = 1'b0;
        #1;
        n_cmp++;
        if ({st.L_READY, st.R_READY} !== 2'b11) begin
            n_err++; $display("FAIL mid_reset_ready: got %b expected 11", {st.L_READY, st.R_READY});
        end
        for (int c = 1; c <= c_FRAME + c_HALF; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_vec !== exp_vec) begin
                n_err++; $display("FAIL pins_post_reset n=%0d: got %h expected %h", n, dut_vec, exp_vec);
            end
            if (AUD_DACDAT) saw_one = 1'b1;
        end
        n_cmp++;
        if ({saw_one, underflow_count} !== {1'b0, 16'd4}) begin
            n_err++; $display("FAIL post_reset_discard: got dat_seen=%b cnt=%0d expected 0 4",
                              saw_one, underflow_count);
        end
    endtask

    initial begin
        st.L_DATA = '0; st.L_VALID = 1'b0;
        st.R_DATA = '0; st.R_VALID = 1'b0;
        reset = 1'b1;
        test_reset();
        test_known_pattern();
        test_back_to_back();
        test_starve();
        test_load_collision();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
